// File: rtl/tank_sprite_pkg.sv
// Shared types and widths for the tank sprite renderer and its animation controller.
package tank_sprite_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  localparam int X_W          = 10;
  localparam int ADDR_W       = 11;
  localparam int IDX_W        = 4;
  localparam int SPRITE_W_DEF = 32;
  localparam int SPRITE_H_DEF = 32;
  localparam int ANIM_DIV_DEF = 8;
  localparam logic [IDX_W-1:0] TRANSPARENT_IDX_DEF = '0;

endpackage

// File: rtl/tank_anim_ctrl.sv
// Per-video-frame latch of sprite position/direction/visibility plus the
// animation divider that toggles the walk frame while the tank moves.
module tank_anim_ctrl
  import tank_sprite_pkg::*;
#(
  parameter int ANIM_DIV = ANIM_DIV_DEF
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           frame_start,
  input  logic [X_W-1:0] tank_x,
  input  logic [X_W-1:0] tank_y,
  input  logic [1:0]     tank_dir,
  input  logic           moving,
  input  logic           enable,
  output logic [X_W-1:0] pos_x,
  output logic [X_W-1:0] pos_y,
  output dir_t           dir,
  output logic           visible,
  output logic           frame
);

  localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pos_x   <= '0;
      pos_y   <= '0;
      dir     <= DIR_UP;
      visible <= 1'b0;
      cnt     <= '0;
      frame   <= 1'b0;
    end else if (frame_start) begin
      pos_x   <= tank_x;
      pos_y   <= tank_y;
      dir     <= dir_t'(tank_dir);
      visible <= enable;
      // a stationary tank keeps its current walk pose
      if (moving) begin
        if (cnt == CNT_LAST) begin
          cnt   <= '0;
          frame <= ~frame;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tank_sprite_renderer.sv
// Three-stage pixel pipeline: box test + rotated ROM address, ROM read,
// then opacity decision feeding the palette stage.
module tank_sprite_renderer
  import tank_sprite_pkg::*;
#(
  parameter int SPRITE_W = SPRITE_W_DEF,
  parameter int SPRITE_H = SPRITE_H_DEF,
  parameter int ANIM_DIV = ANIM_DIV_DEF,
  parameter logic [IDX_W-1:0] TRANSPARENT_IDX = TRANSPARENT_IDX_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic [X_W-1:0]    DrawX,
  input  logic [X_W-1:0]    DrawY,
  input  logic [X_W-1:0]    tank_x,
  input  logic [X_W-1:0]    tank_y,
  input  logic [1:0]        tank_dir,
  input  logic              moving,
  input  logic              enable,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pix_idx,
  output logic              sprite_on
);

  localparam int CW = $clog2(SPRITE_W);
  localparam logic [CW-1:0]  N    = CW'(SPRITE_W - 1);
  localparam logic [X_W:0]   SW_E = (X_W+1)'(SPRITE_W);
  localparam logic [X_W:0]   SH_E = (X_W+1)'(SPRITE_H);

  logic [X_W-1:0] pos_x, pos_y;
  dir_t           dir;
  logic           visible, frame;

  tank_anim_ctrl #(.ANIM_DIV(ANIM_DIV)) u_anim (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .tank_x      (tank_x),
    .tank_y      (tank_y),
    .tank_dir    (tank_dir),
    .moving      (moving),
    .enable      (enable),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .dir         (dir),
    .visible     (visible),
    .frame       (frame)
  );

  // 11-bit compares so a sprite near the right/bottom edge clips instead of wrapping
  logic [X_W:0] dx_e, dy_e, px_e, py_e;
  logic         in_box;
  assign dx_e = {1'b0, DrawX};
  assign dy_e = {1'b0, DrawY};
  assign px_e = {1'b0, pos_x};
  assign py_e = {1'b0, pos_y};
  assign in_box = visible && (dx_e >= px_e) && (dx_e < px_e + SW_E)
                          && (dy_e >= py_e) && (dy_e < py_e + SH_E);

  // only the low bits of the local offset matter once we know we are in the box
  logic [CW-1:0] lx, ly, col, row;
  assign lx = DrawX[CW-1:0] - pos_x[CW-1:0];
  assign ly = DrawY[CW-1:0] - pos_y[CW-1:0];

  always_comb begin
    col = lx;
    row = ly;
    case (dir)
      DIR_UP:    begin col = lx;     row = ly;     end
      DIR_RIGHT: begin col = ly;     row = N - lx; end
      DIR_DOWN:  begin col = N - lx; row = N - ly; end
      DIR_LEFT:  begin col = N - ly; row = lx;     end
      default:   begin col = lx;     row = ly;     end
    endcase
  end

  logic in_box_s1, in_box_s2;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr  <= '0;
      in_box_s1 <= 1'b0;
      in_box_s2 <= 1'b0;
      pix_idx   <= '0;
      sprite_on <= 1'b0;
    end else begin
      rom_addr  <= {frame, row, col};
      in_box_s1 <= in_box;
      in_box_s2 <= in_box_s1;
      if (in_box_s2 && (rom_q != TRANSPARENT_IDX)) begin
        pix_idx   <= rom_q;
        sprite_on <= 1'b1;
      end else begin
        pix_idx   <= '0;
        sprite_on <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tank_sprite_renderer.sv
// Scoreboard bench: stimulus pushes expected address/pixel results computed from
// geometric rules; a negedge monitor pops and compares them as they fall due.
module tb_tank_sprite_renderer;
  import tank_sprite_pkg::*;

  localparam int ANIM_DIV = 4;

  logic        Clk = 1'b0;
  logic        Reset, frame_start, moving, enable;
  logic [9:0]  DrawX, DrawY, tank_x, tank_y;
  logic [1:0]  tank_dir;
  logic [10:0] rom_addr;
  logic [3:0]  rom_q, pix_idx;
  logic        sprite_on;

  always #5 Clk = ~Clk;

  tank_sprite_renderer #(.ANIM_DIV(ANIM_DIV)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .tank_x(tank_x), .tank_y(tank_y),
    .tank_dir(tank_dir), .moving(moving), .enable(enable),
    .rom_addr(rom_addr), .rom_q(rom_q), .pix_idx(pix_idx), .sprite_on(sprite_on)
  );

  logic [3:0] rom [0:2047];
  always @(posedge Clk) rom_q <= rom[rom_addr];

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  bit chk_en = 0;

  // reference state: what the sprite should look like this frame
  int m_x, m_y, m_dir, m_vis, m_moves;

  typedef struct { int due; logic [10:0] addr; logic [3:0] idx; logic on; } exp_t;
  exp_t aq[$], pq[$];
  exp_t me;

  function automatic bit m_inbox(int dx, int dy);
    return (m_vis != 0) && dx >= m_x && dx < m_x + 32 && dy >= m_y && dy < m_y + 32;
  endfunction

  function automatic logic [10:0] m_addr(int dx, int dy);
    int lx, ly, col, row, fr;
    lx = (dx - m_x) & 31;
    ly = (dy - m_y) & 31;
    case (m_dir)
      0:       begin col = lx;      row = ly;      end
      1:       begin col = ly;      row = 31 - lx; end
      2:       begin col = 31 - lx; row = 31 - ly; end
      default: begin col = 31 - ly; row = lx;      end
    endcase
    fr = (m_moves / ANIM_DIV) % 2;
    return 11'(fr * 1024 + row * 32 + col);
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic step(input bit fs, input int dx, input int dy);
    exp_t e;
    bit ib;
    logic [10:0] a;
    frame_start = fs;
    DrawX = 10'(dx);
    DrawY = 10'(dy);
    ib = m_inbox(dx, dy);
    a  = m_addr(dx, dy);
    if (ib) begin
      e.due = cyc + 1; e.addr = a; e.idx = 4'h0; e.on = 1'b0;
      aq.push_back(e);
    end
    e.due  = cyc + 3;
    e.addr = a;
    e.on   = ib && (rom[a] != 4'h0);
    e.idx  = e.on ? rom[a] : 4'h0;
    pq.push_back(e);
    if (fs) begin
      m_x = int'(tank_x); m_y = int'(tank_y); m_dir = int'(tank_dir); m_vis = int'(enable);
      if (moving) m_moves++;
    end
    @(negedge Clk);
  endtask

  task automatic latch(input int x, input int y, input int d, input bit en, input bit mv);
    tank_x = 10'(x); tank_y = 10'(y); tank_dir = 2'(d); enable = en; moving = mv;
    step(1'b1, 0, 0);
  endtask

  always @(negedge Clk) if (chk_en) begin
    while (aq.size() > 0 && aq[0].due <= cyc) begin
      me = aq.pop_front();
      n_cmp++;
      if (me.due != cyc || rom_addr !== me.addr) begin
        n_err++;
        $display("FAIL rom_addr cyc %0d: got %h want %h (due %0d)", cyc, rom_addr, me.addr, me.due);
      end
    end
    while (pq.size() > 0 && pq[0].due <= cyc) begin
      me = pq.pop_front();
      n_cmp++;
      if (me.due != cyc || pix_idx !== me.idx || sprite_on !== me.on) begin
        n_err++;
        $display("FAIL pixel cyc %0d: got idx=%h on=%b want idx=%h on=%b (due %0d)",
                 cyc, pix_idx, sprite_on, me.idx, me.on, me.due);
      end
    end
  end

  initial begin
    int k, dx, dy, t;
    bit fs;
    for (int i = 0; i < 2048; i++)
      rom[i] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    rom[11'h000] = 4'h5;
    rom[11'h001] = 4'h0;
    rom[11'h3FF] = 4'h9;

    // reset must override a simultaneous frame_start
    Reset = 1'b1; frame_start = 1'b1; DrawX = '0; DrawY = '0;
    tank_x = 10'd77; tank_y = 10'd33; tank_dir = 2'b10; enable = 1'b1; moving = 1'b1;
    repeat (2) @(negedge Clk);
    check("reset rom_addr", 32'(rom_addr), 32'h0);
    check("reset pix_idx", 32'(pix_idx), 32'h0);
    check("reset sprite_on", 32'(sprite_on), 32'h0);
    check("reset dir", 32'(dut.u_anim.dir), 32'(DIR_UP));
    check("reset visible", 32'(dut.u_anim.visible), 32'h0);
    Reset = 1'b0; frame_start = 1'b0; moving = 1'b0;
    m_x = 0; m_y = 0; m_dir = 0; m_vis = 0; m_moves = 0;
    chk_en = 1;

    // up hit, then the three rotations hitting the corner addresses
    latch(100, 50, 0, 1, 0);
    step(0, 100, 50);
    latch(100, 50, 1, 1, 0);
    step(0, 131, 50);
    latch(100, 50, 2, 1, 0);
    step(0, 100, 50);
    latch(100, 50, 3, 1, 0);
    step(0, 100, 81);

    // transparent pixel and right-edge clipping
    latch(100, 50, 0, 1, 0);
    step(0, 101, 50);
    step(0, 99, 50);
    latch(620, 100, 0, 1, 0);
    step(0, 639, 100);
    step(0, 619, 100);
    step(0, 0, 101);
    step(0, 620, 131);
    step(0, 620, 132);

    // animation: frame toggles after ANIM_DIV moving pulses, holds when stopped
    latch(100, 50, 0, 1, 1);
    step(1, 0, 0); step(1, 0, 0);
    step(0, 100, 50);
    step(1, 0, 0);
    step(0, 100, 50);
    moving = 1'b0;
    repeat (10) step(1, 0, 0);
    step(0, 100, 50);

    // mid-frame input changes are ignored until the next pulse; pulse coincides with a hit
    latch(200, 40, 0, 1, 0);
    step(0, 200, 60);
    tank_dir = 2'b01; tank_x = 10'd5; enable = 1'b0;
    step(0, 210, 60);
    step(0, 231, 60);
    step(1, 205, 62);
    step(0, 205, 62);

    // randomized frames with mid-frame noise on the tank inputs
    for (int it = 0; it < 600; it++) begin
      fs = ($urandom_range(0, 15) == 0);
      if (fs) begin
        tank_x = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(600, 639)) : 10'($urandom_range(0, 639));
        tank_y = 10'($urandom_range(0, 479));
        tank_dir = 2'($urandom);
        enable = ($urandom_range(0, 9) != 0);
        moving = 1'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        tank_dir = 2'($urandom);
        tank_x = 10'($urandom_range(0, 639));
      end
      if ($urandom_range(0, 4) == 0) begin
        dx = $urandom_range(0, 639);
        dy = $urandom_range(0, 479);
      end else begin
        dx = m_x + $urandom_range(0, 39) - 4;
        dy = m_y + $urandom_range(0, 39) - 4;
      end
      if (dx < 0) dx = 0;
      if (dx > 639) dx = 639;
      if (dy < 0) dy = 0;
      if (dy > 479) dy = 479;
      step(fs, dx, dy);
    end

    // reset while opaque pixels are in flight
    latch(300, 300, 0, 1, 0);
    k = 0;
    for (int i = 0; i < 32; i++)
      if (k == 0 && rom[m_addr(300 + i, 300)] != 4'h0) k = i + 1;
    if (k == 0) k = 1;
    repeat (3) step(0, 300 + k - 1, 300);
    chk_en = 0;
    aq.delete();
    pq.delete();
    Reset = 1'b1;
    @(negedge Clk);
    check("midreset sprite_on", 32'(sprite_on), 32'h0);
    check("midreset pix_idx", 32'(pix_idx), 32'h0);
    check("midreset rom_addr", 32'(rom_addr), 32'h0);
    Reset = 1'b0;
    m_x = 0; m_y = 0; m_dir = 0; m_vis = 0; m_moves = 0;
    chk_en = 1;
    step(0, 0, 0);
    step(0, 300, 300);
    latch(10, 10, 2, 1, 0);
    step(0, 10, 10);
    step(0, 41, 41);

    t = 0;
    while ((aq.size() > 0 || pq.size() > 0) && t < 20) begin
      @(negedge Clk);
      t++;
    end
    check("scoreboard drained", 32'(aq.size() + pq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
